mem_port_arbiter: RTL and testbench

Arbitrates the single shared memory port between the instruction-fetch requester (IF stage) and the data requester (MEM stage) of the 5-stage pipeline, one outstanding transaction at a time. It runs a request/grant/response handshake to memory and returns read data or write acknowledges to the owning requester. It also generates `stall_if` and `stall_mem`, which feed the hazard unit so the pipeline freezes while an access is pending.

---
 rtl/mem_port_arbiter_if.sv | 54 +++++
 rtl/mem_port_arbiter.sv | 142 ++++++++++++++
 tb/tb_mem_port_arbiter.sv | 242 ++++++++++++++++++++++++
 3 files changed

// File: rtl/mem_port_arbiter_if.sv
// Bundle of requester, memory and stall signals for mem_port_arbiter.
// Slave modport is the arbiter view; master modport is the requester/memory side.
interface mem_port_arbiter_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  // Handshake: a requester raises *_req with stable attributes and holds it until
  // its one-cycle *_valid pulse (fetch may also leave via if_kill). The arbiter holds
  // mem_req with stable mem_* attributes until mem_gnt, then waits for one mem_rvalid.
  logic              if_req;
  logic [ADDR_W-1:0] if_addr;
  logic              if_kill;
  logic [DATA_W-1:0] if_rdata;
  logic              if_valid;

  logic                d_req;
  logic                d_we;
  logic [ADDR_W-1:0]   d_addr;
  logic [DATA_W-1:0]   d_wdata;
  logic [DATA_W/8-1:0] d_be;
  logic [DATA_W-1:0]   d_rdata;
  logic                d_valid;

  logic                mem_req;
  logic                mem_we;
  logic [ADDR_W-1:0]   mem_addr;
  logic [DATA_W-1:0]   mem_wdata;
  logic [DATA_W/8-1:0] mem_be;
  logic                mem_gnt;
  logic                mem_rvalid;
  logic [DATA_W-1:0]   mem_rdata;

  logic       stall_if;
  logic       stall_mem;
  logic [1:0] state_dbg;

  modport slave (
    input  if_req, if_addr, if_kill,
    input  d_req, d_we, d_addr, d_wdata, d_be,
    input  mem_gnt, mem_rvalid, mem_rdata,
    output if_rdata, if_valid, d_rdata, d_valid,
    output mem_req, mem_we, mem_addr, mem_wdata, mem_be,
    output stall_if, stall_mem, state_dbg
  );

  modport master (
    output if_req, if_addr, if_kill,
    output d_req, d_we, d_addr, d_wdata, d_be,
    output mem_gnt, mem_rvalid, mem_rdata,
    input  if_rdata, if_valid, d_rdata, d_valid,
    input  mem_req, mem_we, mem_addr, mem_wdata, mem_be,
    input  stall_if, stall_mem, state_dbg
  );
endinterface

// File: rtl/mem_port_arbiter.sv
// Shares one memory port between fetch and data requesters, one transaction at a time.
// Define MEM_ARB_FAIRNESS_EN to bound consecutive data grants while fetch waits.
module mem_port_arbiter #(
  parameter int ADDR_W          = 32,
  parameter int DATA_W          = 32,
  parameter int MAX_DATA_STREAK = 3
) (
  input  logic              clk,
  input  logic              reset,
  mem_port_arbiter_if.slave bus
);
  localparam int BE_W = DATA_W / 8;

  if (MAX_DATA_STREAK < 1) begin : g_bad_streak
    $error("MAX_DATA_STREAK must be at least 1");
  end

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2
  } state_t;

  state_t            state_q;
  logic              owner_is_data_q;
  logic              kill_q;
  logic              mem_req_q;
  logic              mem_we_q;
  logic [ADDR_W-1:0] mem_addr_q;
  logic [DATA_W-1:0] mem_wdata_q;
  logic [BE_W-1:0]   mem_be_q;
  logic [DATA_W-1:0] if_rdata_q;
  logic              if_valid_q;
  logic [DATA_W-1:0] d_rdata_q;
  logic              d_valid_q;

  logic if_elig;
  logic fetch_wins;

  // A fetch being cancelled this cycle must not win the port.
  assign if_elig = bus.if_req & ~bus.if_kill;

`ifdef MEM_ARB_FAIRNESS_EN
  localparam int SW = $clog2(MAX_DATA_STREAK + 1);
  localparam logic [SW-1:0] STREAK_MAX = SW'(MAX_DATA_STREAK);

  logic [SW-1:0] streak_q;

  assign fetch_wins = if_elig & (~bus.d_req | (streak_q == STREAK_MAX));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      streak_q <= '0;
    end else if (state_q == IDLE) begin
      if (!bus.if_req || fetch_wins) begin
        streak_q <= '0;
      end else if (bus.d_req && if_elig && (streak_q != STREAK_MAX)) begin
        streak_q <= streak_q + 1'b1;
      end
    end
  end
`else
  assign fetch_wins = if_elig & ~bus.d_req;
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q         <= IDLE;
      owner_is_data_q <= 1'b0;
      kill_q          <= 1'b0;
      mem_req_q       <= 1'b0;
      mem_we_q        <= 1'b0;
      mem_addr_q      <= '0;
      mem_wdata_q     <= '0;
      mem_be_q        <= '0;
      if_rdata_q      <= '0;
      if_valid_q      <= 1'b0;
      d_rdata_q       <= '0;
      d_valid_q       <= 1'b0;
    end else begin
      if_valid_q <= 1'b0;
      d_valid_q  <= 1'b0;
      case (state_q)
        IDLE: begin
          kill_q <= 1'b0;
          if (fetch_wins) begin
            owner_is_data_q <= 1'b0;
            mem_we_q        <= 1'b0;
            mem_addr_q      <= bus.if_addr;
            mem_wdata_q     <= '0;
            mem_be_q        <= '1;
            mem_req_q       <= 1'b1;
            state_q         <= ISSUE;
          end else if (bus.d_req) begin
            owner_is_data_q <= 1'b1;
            mem_we_q        <= bus.d_we;
            mem_addr_q      <= bus.d_addr;
            mem_wdata_q     <= bus.d_wdata;
            mem_be_q        <= bus.d_be;
            mem_req_q       <= 1'b1;
            state_q         <= ISSUE;
          end
        end
        ISSUE: begin
          if (!owner_is_data_q && bus.if_kill) kill_q <= 1'b1;
          if (bus.mem_gnt) begin
            mem_req_q <= 1'b0;
            state_q   <= WAIT;
          end
        end
        WAIT: begin
          if (!owner_is_data_q && bus.if_kill) kill_q <= 1'b1;
          if (bus.mem_rvalid) begin
            state_q <= IDLE;
            if (owner_is_data_q) begin
              d_valid_q <= 1'b1;
              if (!mem_we_q) d_rdata_q <= bus.mem_rdata;
            end else if (!kill_q && !bus.if_kill) begin
              // A killed fetch still drains the bus but leaves no trace.
              if_valid_q <= 1'b1;
              if_rdata_q <= bus.mem_rdata;
            end
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.mem_req   = mem_req_q;
  assign bus.mem_we    = mem_we_q;
  assign bus.mem_addr  = mem_addr_q;
  assign bus.mem_wdata = mem_wdata_q;
  assign bus.mem_be    = mem_be_q;
  assign bus.if_rdata  = if_rdata_q;
  assign bus.if_valid  = if_valid_q;
  assign bus.d_rdata   = d_rdata_q;
  assign bus.d_valid   = d_valid_q;
  assign bus.stall_if  = bus.if_req & ~if_valid_q;
  assign bus.stall_mem = bus.d_req & ~d_valid_q;
  assign bus.state_dbg = state_q;
endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: cycle-accurate stimulus with hand-computed results.
module tb_mem_port_arbiter;
  localparam int ADDR_W = 32;
  localparam int DATA_W = 32;
  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_ISSUE = 2'd1;
  localparam logic [1:0] S_WAIT  = 2'd2;

  logic clk;
  logic reset;
  int   checks   = 0;
  int   failures = 0;
  logic [ADDR_W-1:0] exp_q[$];

  mem_port_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

  mem_port_arbiter #(
    .ADDR_W(ADDR_W), .DATA_W(DATA_W), .MAX_DATA_STREAK(3)
  ) dut (
    .clk(clk), .reset(reset), .bus(bus)
  );

  // clock / reset
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // driver tasks: inputs change 1 time unit after the edge, outputs are read 1 unit later
  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic idle_inputs();
    bus.if_req = 1'b0; bus.if_addr = '0; bus.if_kill = 1'b0;
    bus.d_req = 1'b0; bus.d_we = 1'b0; bus.d_addr = '0; bus.d_wdata = '0; bus.d_be = '0;
    bus.mem_gnt = 1'b0; bus.mem_rvalid = 1'b0; bus.mem_rdata = '0;
  endtask

  task automatic check_reset_values(input string tag);
    check_eq({tag, "_mem_req"}, bus.mem_req, 0);
    check_eq({tag, "_mem_we"}, bus.mem_we, 0);
    check_eq({tag, "_mem_addr"}, bus.mem_addr, 0);
    check_eq({tag, "_mem_wdata"}, bus.mem_wdata, 0);
    check_eq({tag, "_mem_be"}, bus.mem_be, 0);
    check_eq({tag, "_if_valid"}, bus.if_valid, 0);
    check_eq({tag, "_d_valid"}, bus.d_valid, 0);
    check_eq({tag, "_if_rdata"}, bus.if_rdata, 0);
    check_eq({tag, "_d_rdata"}, bus.d_rdata, 0);
    check_eq({tag, "_state"}, bus.state_dbg, S_IDLE);
  endtask

  initial begin
    logic [ADDR_W-1:0] exp_addr;
    bit fair;
`ifdef MEM_ARB_FAIRNESS_EN
    fair = 1'b1;
`else
    fair = 1'b0;
`endif
    reset = 1'b1;
    idle_inputs();
    repeat (3) next_cycle();
    settle();
    check_reset_values("por");
    reset = 1'b0;

    // single fetch
    next_cycle();
    bus.if_req = 1'b1; bus.if_addr = 32'h100; settle();
    check_eq("f1_c0_stall_if", bus.stall_if, 1);
    check_eq("f1_c0_mem_req", bus.mem_req, 0);
    next_cycle();
    bus.mem_gnt = 1'b1; settle();
    check_eq("f1_c1_mem_req", bus.mem_req, 1);
    check_eq("f1_c1_mem_addr", bus.mem_addr, 32'h100);
    check_eq("f1_c1_mem_we", bus.mem_we, 0);
    check_eq("f1_c1_mem_be", bus.mem_be, 4'hF);
    check_eq("f1_c1_stall_if", bus.stall_if, 1);
    next_cycle();
    bus.mem_gnt = 1'b0; bus.mem_rvalid = 1'b1; bus.mem_rdata = 32'hDEADBEEF; settle();
    check_eq("f1_c2_mem_req", bus.mem_req, 0);
    check_eq("f1_c2_state", bus.state_dbg, S_WAIT);
    check_eq("f1_c2_stall_if", bus.stall_if, 1);
    next_cycle();
    bus.mem_rvalid = 1'b0; settle();
    check_eq("f1_c3_if_valid", bus.if_valid, 1);
    check_eq("f1_c3_if_rdata", bus.if_rdata, 32'hDEADBEEF);
    check_eq("f1_c3_stall_if", bus.stall_if, 0);
    check_eq("f1_c3_d_valid", bus.d_valid, 0);
    bus.if_req = 1'b0;
    next_cycle();
    check_eq("f1_c4_if_valid", bus.if_valid, 0);
    check_eq("f1_c4_state", bus.state_dbg, S_IDLE);
    check_eq("f1_c4_mem_req", bus.mem_req, 0);

    // simultaneous fetch and load: data first
    bus.if_req = 1'b1; bus.if_addr = 32'h104;
    bus.d_req = 1'b1; bus.d_we = 1'b0; bus.d_addr = 32'h200; bus.d_be = 4'hF; settle();
    check_eq("sim_c0_stall_if", bus.stall_if, 1);
    check_eq("sim_c0_stall_mem", bus.stall_mem, 1);
    next_cycle();
    bus.mem_gnt = 1'b1; settle();
    check_eq("sim_d_mem_addr", bus.mem_addr, 32'h200);
    check_eq("sim_d_mem_we", bus.mem_we, 0);
    next_cycle();
    bus.mem_gnt = 1'b0; bus.mem_rvalid = 1'b1; bus.mem_rdata = 32'hA5A50001; settle();
    next_cycle();
    bus.mem_rvalid = 1'b0; settle();
    check_eq("sim_d_valid", bus.d_valid, 1);
    check_eq("sim_d_rdata", bus.d_rdata, 32'hA5A50001);
    check_eq("sim_d_if_valid", bus.if_valid, 0);
    check_eq("sim_d_stall_mem", bus.stall_mem, 0);
    check_eq("sim_d_stall_if", bus.stall_if, 1);
    bus.d_req = 1'b0;
    next_cycle();
    bus.mem_gnt = 1'b1; settle();
    check_eq("sim_f_mem_req", bus.mem_req, 1);
    check_eq("sim_f_mem_addr", bus.mem_addr, 32'h104);
    check_eq("sim_f_d_valid", bus.d_valid, 0);
    next_cycle();
    bus.mem_gnt = 1'b0; bus.mem_rvalid = 1'b1; bus.mem_rdata = 32'h0BADF00D; settle();
    next_cycle();
    bus.mem_rvalid = 1'b0; settle();
    check_eq("sim_f_if_valid", bus.if_valid, 1);
    check_eq("sim_f_if_rdata", bus.if_rdata, 32'h0BADF00D);
    check_eq("sim_f_d_rdata_kept", bus.d_rdata, 32'hA5A50001);
    bus.if_req = 1'b0;

    // store with grant held off for 4 cycles; stray rvalid in ISSUE is ignored
    next_cycle();
    bus.d_req = 1'b1; bus.d_we = 1'b1; bus.d_addr = 32'h300;
    bus.d_wdata = 32'h12345678; bus.d_be = 4'b0011; settle();
    for (int c = 1; c <= 5; c++) begin
      next_cycle();
      bus.mem_gnt = (c == 5);
      bus.mem_rvalid = (c == 2);
      bus.mem_rdata = 32'hFFFFFFFF;
      settle();
      check_eq($sformatf("st_c%0d_mem_req", c), bus.mem_req, 1);
      check_eq($sformatf("st_c%0d_mem_we", c), bus.mem_we, 1);
      check_eq($sformatf("st_c%0d_mem_addr", c), bus.mem_addr, 32'h300);
      check_eq($sformatf("st_c%0d_mem_wdata", c), bus.mem_wdata, 32'h12345678);
      check_eq($sformatf("st_c%0d_mem_be", c), bus.mem_be, 4'b0011);
      check_eq($sformatf("st_c%0d_d_valid", c), bus.d_valid, 0);
      check_eq($sformatf("st_c%0d_state", c), bus.state_dbg, S_ISSUE);
    end
    next_cycle();
    bus.mem_gnt = 1'b0; bus.mem_rvalid = 1'b1; settle();
    check_eq("st_wait_mem_req", bus.mem_req, 0);
    check_eq("st_wait_state", bus.state_dbg, S_WAIT);
    next_cycle();
    bus.mem_rvalid = 1'b0; settle();
    check_eq("st_d_valid", bus.d_valid, 1);
    check_eq("st_d_rdata_kept", bus.d_rdata, 32'hA5A50001);
    bus.d_req = 1'b0; bus.d_we = 1'b0;

    // fetch killed while waiting for data
    next_cycle();
    bus.if_req = 1'b1; bus.if_addr = 32'h400; settle();
    next_cycle();
    bus.mem_gnt = 1'b1; settle();
    check_eq("kill_mem_addr", bus.mem_addr, 32'h400);
    next_cycle();
    bus.mem_gnt = 1'b0; bus.if_kill = 1'b1; settle();
    check_eq("kill_state_wait", bus.state_dbg, S_WAIT);
    next_cycle();
    bus.if_kill = 1'b0; bus.if_req = 1'b0;
    bus.mem_rvalid = 1'b1; bus.mem_rdata = 32'h55555555; settle();
    next_cycle();
    bus.mem_rvalid = 1'b0; settle();
    check_eq("kill_if_valid", bus.if_valid, 0);
    check_eq("kill_if_rdata_kept", bus.if_rdata, 32'h0BADF00D);
    check_eq("kill_state_idle", bus.state_dbg, S_IDLE);
    next_cycle();
    check_eq("kill_if_valid_late", bus.if_valid, 0);

    // reset during ISSUE, then a normal load
    bus.d_req = 1'b1; bus.d_we = 1'b0; bus.d_addr = 32'h500; bus.d_be = 4'hF; settle();
    next_cycle();
    settle();
    check_eq("rst_pre_mem_req", bus.mem_req, 1);
    reset = 1'b1; settle();
    check_reset_values("rst_mid");
    next_cycle();
    reset = 1'b0; settle();
    check_eq("rst_rel_state", bus.state_dbg, S_IDLE);
    next_cycle();
    bus.mem_gnt = 1'b1; settle();
    check_eq("rst_rel_mem_req", bus.mem_req, 1);
    check_eq("rst_rel_mem_addr", bus.mem_addr, 32'h500);
    next_cycle();
    bus.mem_gnt = 1'b0; bus.mem_rvalid = 1'b1; bus.mem_rdata = 32'hCAFEF00D; settle();
    next_cycle();
    bus.mem_rvalid = 1'b0; settle();
    check_eq("rst_rel_d_valid", bus.d_valid, 1);
    check_eq("rst_rel_d_rdata", bus.d_rdata, 32'hCAFEF00D);
    bus.d_req = 1'b0;

    // both requesters held: grant order against the expected queue
    next_cycle();
    bus.d_req = 1'b1; bus.d_we = 1'b0; bus.d_addr = 32'h600; bus.d_be = 4'hF;
    bus.if_req = 1'b1; bus.if_addr = 32'h700;
    for (int i = 0; i < 8; i++) exp_q.push_back((fair && (i % 4 == 3)) ? 32'h700 : 32'h600);
    for (int i = 0; i < 8; i++) begin
      next_cycle();
      bus.mem_gnt = 1'b1; settle();
      exp_addr = exp_q.pop_front();
      check_eq($sformatf("ord%0d_mem_req", i), bus.mem_req, 1);
      check_eq($sformatf("ord%0d_mem_addr", i), bus.mem_addr, exp_addr);
      next_cycle();
      bus.mem_gnt = 1'b0; bus.mem_rvalid = 1'b1; bus.mem_rdata = 32'(i); settle();
      next_cycle();
      bus.mem_rvalid = 1'b0; settle();
      check_eq($sformatf("ord%0d_d_valid", i), bus.d_valid, exp_addr == 32'h600);
      check_eq($sformatf("ord%0d_if_valid", i), bus.if_valid, exp_addr == 32'h700);
      if (i == 7) begin
        bus.d_req = 1'b0; bus.if_req = 1'b0;
      end
    end
    next_cycle();
    next_cycle();
    check_eq("end_state_idle", bus.state_dbg, S_IDLE);
    check_eq("end_mem_req", bus.mem_req, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
